alu: RTL and testbench
======================

# alu

Single-cycle integer ALU for the R-type datapath. It decodes the 6-bit `funct` field and computes an add, subtract, logic, shift or compare result from the two register operands. The result is held in a register that updates on the clock. It sits between register-file read and write-back in the execute stage.

## Interface
Parameters: none; operand width is fixed at 32.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rs_data`  input  32  first operand; also the value being shifted by all shift ops.
- `rt_data`  input  32  second operand; `rt_data[4:0]` is the variable shift amount.
- `funct`  input  6  operation select (codes below).
- `shamt`  input  5  immediate shift amount for SLL/SRL/SRA.
- `result`  output  32  registered operation result.

## Operation
Funct codes are MIPS-encoded. All arithmetic is modulo 2^32 and no op traps.
- ADDU `6'h21`: `rs_data + rt_data`, carry discarded.
- SUBU `6'h23`: `rs_data - rt_data`, borrow discarded.
- AND `6'h24`, OR `6'h25`, XOR `6'h26`, NOR `6'h27`: bitwise ops on rs and rt.
- SLL `6'h00`: `rs_data << shamt`.
- SRL `6'h02`: `rs_data >> shamt`, zero fill.
- SRA `6'h03`: `rs_data >>> shamt`, sign fill from `rs_data[31]`.
- SLLV `6'h04`, SRLV `6'h06`, SRAV `6'h07`: same shifts as above, using `rt_data[4:0]` as the amount. `rt_data[31:5]` is ignored.
- SLT `6'h2A`: result is 1 if signed `rs_data < rt_data`, else 0.
- SLTU `6'h2B`: result is 1 if unsigned `rs_data < rt_data`, else 0. Available only with the configuration macro.
- Any other funct value gives a result of `32'h0`.
- Shift by 0 passes `rs_data` through unchanged.
- `shamt` is ignored for every non-immediate-shift op.

## Timing
- The next result is computed combinationally from the current inputs.
- `result` is loaded on each rising edge of `clk`: latency is 1 cycle and throughput is 1 op per cycle.
- There is no enable and no handshake. Inputs must be stable around the clock edge.
- When `rst` is asserted, `result` goes to `32'h0` immediately, independent of `clk`.
- `result` stays 0 while `rst` is high. The first capture happens on the first rising edge after `rst` is deasserted.
- If `rst` asserts during an operation, that operation is discarded.

## Configuration
- Macro: `ALU_SLT_EN`.
- Defined: SLT and SLTU are decoded as specified above.
- Undefined: `6'h2A` and `6'h2B` are treated as unsupported and give `32'h0`, and the comparator logic is not instantiated.
- All other ops are unaffected either way.

## Structure
- Shared package `alu_pkg` holds:
  - the funct code localparams `ADDU`, `SUBU`, `AND`, `OR`, `XOR`, `NOR`, `SLL`, `SRL`, `SRA`, `SLLV`, `SRLV`, `SRAV`, `SLT`, `SLTU`;
  - the width constant `ALU_W = 32`.
- One sub-module, `alu_shifter`: a combinational 32-bit barrel shifter.
  - Inputs: data, 5-bit amount, and a direction/arith select.
  - The amount comes from `shamt` or `rt_data[4:0]`; the parent muxes which one.
- The top level holds the funct decode, the adder/subtractor, the logic ops, the optional comparator, and the result register.

## Test plan
Unless noted, apply inputs with `rst` low, clock one edge, then check `result`.
- Reset: assert `rst` mid-cycle while `result` is nonzero -> `result` = 0 with no clock edge; it stays 0 until the first edge after release.
- ADDU 10+20 -> 30. SUBU 30-10 -> 20. SUBU 0-1 -> `32'hFFFFFFFF`. ADDU `32'hFFFFFFFF`+1 -> 0.
- SLL rs=5, shamt=2 -> 20. SLLV rs=8, rt=2 -> 32. SLLV rs=1, rt=`32'h21` -> 2 (only `rt[4:0]` used).
- SRA rs=`32'h80000000`, shamt=4 -> `32'hF8000000`. SRL with the same operands -> `32'h08000000`. Shift by 0 -> `rs_data`.
- With `ALU_SLT_EN`: SLT rs=-1, rt=1 -> 1; SLTU with the same operands -> 0. Without the macro: both -> 0.
- Unsupported funct `6'h3F` -> 0. Back-to-back ops on consecutive cycles each appear exactly one edge later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage integer ALU:
// MIPS R-type funct codes, datapath width and a bit-reverse helper.
package alu_pkg;

   localparam int ALU_W = 32;

   localparam logic [5:0] SLL  = 6'h00;
   localparam logic [5:0] SRL  = 6'h02;
   localparam logic [5:0] SRA  = 6'h03;
   localparam logic [5:0] SLLV = 6'h04;
   localparam logic [5:0] SRLV = 6'h06;
   localparam logic [5:0] SRAV = 6'h07;
   localparam logic [5:0] ADDU = 6'h21;
   localparam logic [5:0] SUBU = 6'h23;
   localparam logic [5:0] AND  = 6'h24;
   localparam logic [5:0] OR   = 6'h25;
   localparam logic [5:0] XOR  = 6'h26;
   localparam logic [5:0] NOR  = 6'h27;
   localparam logic [5:0] SLT  = 6'h2A;
   localparam logic [5:0] SLTU = 6'h2B;

   // Mirror a word so a single right-shifting network can also shift left.
   function automatic logic [ALU_W-1:0] bit_rev(
      input logic [ALU_W-1:0] d
   );
      logic [ALU_W-1:0] r;
      for (int i = 0; i < ALU_W; i++)
         r[i] = d[ALU_W-1-i];
      return r;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter: logical left, logical right,
// arithmetic right. Left shifts reuse the right network via bit reversal.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] data,
   input  logic [4:0]       amt,
   input  logic             right,
   input  logic             arith,
   output logic [ALU_W-1:0] out
);

   logic             fill;
   logic [ALU_W-1:0] s0;
   logic [ALU_W-1:0] s1;
   logic [ALU_W-1:0] s2;
   logic [ALU_W-1:0] s3;
   logic [ALU_W-1:0] s4;
   logic [ALU_W-1:0] s5;

   // Five log-stages of right shift; sign fill only for arithmetic right.
   always_comb begin
      fill = right & arith & data[ALU_W-1];
      s0   = right ? data : bit_rev(data);
      s1   = amt[0] ? {{1{fill}},  s0[ALU_W-1:1]}  : s0;
      s2   = amt[1] ? {{2{fill}},  s1[ALU_W-1:2]}  : s1;
      s3   = amt[2] ? {{4{fill}},  s2[ALU_W-1:4]}  : s2;
      s4   = amt[3] ? {{8{fill}},  s3[ALU_W-1:8]}  : s3;
      s5   = amt[4] ? {{16{fill}}, s4[ALU_W-1:16]} : s4;
      out  = right ? s5 : bit_rev(s5);
   end

endmodule

// File: rtl/alu.sv
// Single-cycle R-type integer ALU with a registered result.
// Optional SLT/SLTU compare ops are built only when ALU_SLT_EN is defined.
module alu
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [ALU_W-1:0] rs_data,
   input  logic [ALU_W-1:0] rt_data,
   input  logic [5:0]       funct,
   input  logic [4:0]       shamt,
   output logic [ALU_W-1:0] result
);

   logic [4:0]       sh_amt;
   logic             sh_right;
   logic             sh_arith;
   logic [ALU_W-1:0] sh_out;
   logic [ALU_W-1:0] sum;
   logic [ALU_W-1:0] diff;
   logic [ALU_W-1:0] nxt;

   // Variable shifts (funct[2] set) take the amount from rt, else shamt.
   always_comb begin
      sh_amt   = funct[2] ? rt_data[4:0] : shamt;
      sh_right = funct[1];
      sh_arith = funct[0];
   end

   alu_shifter u_shifter (
      .data  (rs_data),
      .amt   (sh_amt),
      .right (sh_right),
      .arith (sh_arith),
      .out   (sh_out)
   );

   // Modulo-2^32 add and subtract; carry and borrow are dropped.
   always_comb begin
      sum  = rs_data + rt_data;
      diff = rs_data - rt_data;
   end

`ifdef ALU_SLT_EN
   logic lt_s;
   logic lt_u;

   // Signed and unsigned less-than for the set-on-compare ops.
   always_comb begin
      lt_s = $signed(rs_data) < $signed(rt_data);
      lt_u = rs_data < rt_data;
   end
`endif

   // Funct decode; anything not listed yields zero.
   always_comb begin
      nxt = '0;
      unique case (funct)
         ADDU: nxt = sum;
         SUBU: nxt = diff;
         AND:  nxt = rs_data & rt_data;
         OR:   nxt = rs_data | rt_data;
         XOR:  nxt = rs_data ^ rt_data;
         NOR:  nxt = ~(rs_data | rt_data);
         SLL:  nxt = sh_out;
         SRL:  nxt = sh_out;
         SRA:  nxt = sh_out;
         SLLV: nxt = sh_out;
         SRLV: nxt = sh_out;
         SRAV: nxt = sh_out;
`ifdef ALU_SLT_EN
         SLT:  nxt = {{(ALU_W-1){1'b0}}, lt_s};
         SLTU: nxt = {{(ALU_W-1){1'b0}}, lt_u};
`endif
         default: nxt = '0;
      endcase
   end

   // Result register; reset clears it at once and discards any op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         result <= '0;
      else
         result <= nxt;
   end

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for the registered ALU,
// plus hand sequences for async reset and back-to-back ops.
module tb_alu;
   import alu_pkg::*;

   typedef struct {
      string       name;
      logic [5:0]  funct;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  shamt;
      logic [31:0] exp;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] result;

   int nvec;
   int nfail;

   vec_t vecs[$];

   alu dut (
      .clk     (clk),
      .rst     (rst),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .funct   (funct),
      .shamt   (shamt),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] s);
      funct   = f;
      rs_data = a;
      rt_data = b;
      shamt   = s;
   endtask

   task automatic add(input string n, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] s, input logic [31:0] e);
      vec_t v;
      v.name = n; v.funct = f; v.rs = a; v.rt = b;
      v.shamt = s; v.exp = e;
      vecs.push_back(v);
   endtask

   logic [31:0] slt_a;
   logic [31:0] slt_b;
   logic [31:0] sltu_a;
   logic [31:0] sltu_b;

   initial begin
      nvec  = 0;
      nfail = 0;
`ifdef ALU_SLT_EN
      slt_a = 32'd1; slt_b = 32'd0;
      sltu_a = 32'd0; sltu_b = 32'd1;
`else
      slt_a = 32'd0; slt_b = 32'd0;
      sltu_a = 32'd0; sltu_b = 32'd0;
`endif

      add("addu",      ADDU, 32'd10, 32'd20, 5'd0, 32'd30);
      add("subu",      SUBU, 32'd30, 32'd10, 5'd0, 32'd20);
      add("subu_wrap", SUBU, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF);
      add("addu_wrap", ADDU, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0);
      add("addu_shamt",ADDU, 32'd7, 32'd8, 5'd31, 32'd15);
      add("and",  AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000);
      add("or",   OR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0);
      add("xor",  XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0);
      add("nor",  NOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h000F000F);
      add("sll",       SLL,  32'd5, 32'd0, 5'd2, 32'd20);
      add("sllv",      SLLV, 32'd8, 32'd2, 5'd0, 32'd32);
      add("sllv_mask", SLLV, 32'd1, 32'h21, 5'd0, 32'd2);
      add("sllv_shamt",SLLV, 32'd1, 32'd4, 5'd3, 32'd16);
      add("sra",  SRA, 32'h80000000, 32'd0, 5'd4, 32'hF8000000);
      add("srl",  SRL, 32'h80000000, 32'd0, 5'd4, 32'h08000000);
      add("sll0", SLL, 32'hDEADBEEF, 32'd0, 5'd0, 32'hDEADBEEF);
      add("srav0",SRAV,32'hDEADBEEF, 32'h20, 5'd9, 32'hDEADBEEF);
      add("srav31",SRAV,32'h80000000,32'hFFFFFFFF,5'd0,32'hFFFFFFFF);
      add("srlv31",SRLV,32'h80000000,32'hFFFFFFFF,5'd0,32'd1);
      add("sra_pos",SRA, 32'h40000000, 32'd0, 5'd30, 32'd1);
      add("slt",  SLT,  32'hFFFFFFFF, 32'd1, 5'd0, slt_a);
      add("sltu", SLTU, 32'hFFFFFFFF, 32'd1, 5'd0, sltu_a);
      add("slt2", SLT,  32'd5, 32'hFFFFFFFD, 5'd0, slt_b);
      add("sltu2",SLTU, 32'd1, 32'hFFFFFFFF, 5'd0, sltu_b);
      add("bad3f",6'h3F, 32'h12345678, 32'h9, 5'd1, 32'd0);
      add("bad01",6'h01, 32'h12345678, 32'h9, 5'd1, 32'd0);

      rst = 1'b1;
      drive(ADDU, 32'd1, 32'd2, 5'd0);
      #1;
      check("reset_val", result, 32'd0);
      @(posedge clk);
      #1;
      check("reset_hold", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].funct, vecs[i].rs, vecs[i].rt, vecs[i].shamt);
         @(posedge clk);
         #1;
         check(vecs[i].name, result, vecs[i].exp);
         @(negedge clk);
      end

      // Back-to-back ops: each appears exactly one edge later.
      drive(ADDU, 32'd100, 32'd1, 5'd0);
      @(posedge clk);
      #1;
      check("b2b_0", result, 32'd101);
      drive(SUBU, 32'd100, 32'd1, 5'd0);
      #1;
      check("b2b_hold", result, 32'd101);
      @(posedge clk);
      #1;
      check("b2b_1", result, 32'd99);
      drive(SLL, 32'd3, 32'd0, 5'd4);
      @(posedge clk);
      #1;
      check("b2b_2", result, 32'd48);

      // Async reset mid-cycle with a nonzero result.
      @(negedge clk);
      drive(XOR, 32'hAAAA5555, 32'd0, 5'd0);
      @(posedge clk);
      #1;
      check("pre_rst", result, 32'hAAAA5555);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst", result, 32'd0);
      @(posedge clk);
      #1;
      check("rst_held", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_rel", result, 32'd0);
      @(posedge clk);
      #1;
      check("first_cap", result, 32'hAAAA5555);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
